// File: rtl/fpu_add_arb.sv
// Round-robin arbiter and sequencer that shares one external combinational FP adder
// between two valid/ready requesters and returns each result on the granted response channel.
module fpu_add_arb #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_result,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_result,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_result,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic             prio;
    logic             gnt_id;
    logic [3:0]       cnt;
    logic [31:0]      op_a, op_b, res;
    logic [CNT_W-1:0] done_cnt_q;

    logic             gnt_valid;
    logic             gnt;
    logic             accept;
    logic             rsp_hs;

    // Combinational grant: a lone requester wins, a tie goes to the priority pointer.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        gnt_valid = req0_valid | req1_valid;
        gnt       = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt = prio;
        end else begin
            gnt = req1_valid;
        end
    end

    assign accept     = (state == IDLE) && gnt_valid;
    assign req0_ready = accept && !gnt;
    assign req1_ready = accept && gnt;
    assign rsp_hs     = (state == RESP) && (gnt_id ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid)   state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_hs)      state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prio       <= 1'b0;
            gnt_id     <= 1'b0;
            cnt        <= 4'd0;
            // NOTE: datapath registers are reset too, so the adder inputs and results read 0 out of reset.
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            res        <= 32'd0;
            done_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= gnt ? req1_a : req0_a;
                        op_b   <= gnt ? req1_b : req0_b;
                        gnt_id <= gnt;
                        cnt    <= SETTLE_LOAD;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res <= add_result;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        done_cnt_q <= done_cnt_q + CNT_W'(1);
                        prio       <= ~gnt_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operands persist on the adder between transactions; results appear only on the granted channel in RESP.
    assign add_a       = op_a;
    assign add_b       = op_b;
    assign rsp0_valid  = (state == RESP) && !gnt_id;
    assign rsp1_valid  = (state == RESP) && gnt_id;
    assign rsp0_result = rsp0_valid ? res : 32'd0;
    assign rsp1_result = rsp1_valid ? res : 32'd0;
    assign busy        = (state != IDLE);
    assign done_count  = done_cnt_q;

endmodule

// File: tb/tb_fpu_add_arb.sv
// Directed bench for fpu_add_arb: one instance with SETTLE_CYCLES=1, one with 4,
// each driving a small lookup-based adder model.
module tb_fpu_add_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Adder model: the test plan's float sums, otherwise an integer sum so muxing errors show up.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (a == 32'h3FC00000 && b == 32'h40200000) return 32'h40800000;
        if (a == 32'h40000000 && b == 32'h40400000) return 32'h40A00000;
        return a + b;
    endfunction

    // Instance with SETTLE_CYCLES = 1
    logic        r0v = 0, r1v = 0, s0r = 0, s1r = 0;
    logic [31:0] r0a = 0, r0b = 0, r1a = 0, r1b = 0;
    logic        r0r, r1r, s0v, s1v, busy;
    logic [31:0] s0res, s1res, add_a, add_b, add_res;
    logic [15:0] dcnt;
    assign add_res = fadd(add_a, add_b);

    fpu_add_arb #(.SETTLE_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
        .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp0_result(s0res),
        .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
        .rsp1_valid(s1v), .rsp1_ready(s1r), .rsp1_result(s1res),
        .add_a(add_a), .add_b(add_b), .add_result(add_res),
        .busy(busy), .done_count(dcnt)
    );

    // Instance with SETTLE_CYCLES = 4 (channel 1 idle)
    logic        r0v4 = 0, r1v4 = 0, s0r4 = 0, s1r4 = 0;
    logic [31:0] r0a4 = 0, r0b4 = 0, r1a4 = 0, r1b4 = 0;
    logic        r0r4, r1r4, s0v4, s1v4, busy4;
    logic [31:0] s0res4, s1res4, add_a4, add_b4, add_res4;
    logic [15:0] dcnt4;
    assign add_res4 = fadd(add_a4, add_b4);

    fpu_add_arb #(.SETTLE_CYCLES(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v4), .req0_ready(r0r4), .req0_a(r0a4), .req0_b(r0b4),
        .rsp0_valid(s0v4), .rsp0_ready(s0r4), .rsp0_result(s0res4),
        .req1_valid(r1v4), .req1_ready(r1r4), .req1_a(r1a4), .req1_b(r1b4),
        .rsp1_valid(s1v4), .rsp1_ready(s1r4), .rsp1_result(s1res4),
        .add_a(add_a4), .add_b(add_b4), .add_result(add_res4),
        .busy(busy4), .done_count(dcnt4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({r0r, r1r, s0v, s1v} !== 4'b0) begin failures++; $display("FAIL reset_handshake: got %b want 0000", {r0r, r1r, s0v, s1v}); end
        checks++; if ({s0res, s1res} !== 64'd0) begin failures++; $display("FAIL reset_results: got %h want 0", {s0res, s1res}); end
        checks++; if ({add_a, add_b} !== 64'd0) begin failures++; $display("FAIL reset_add_ops: got %h want 0", {add_a, add_b}); end
        checks++; if (dcnt !== 16'd0) begin failures++; $display("FAIL reset_done_count: got %0d want 0", dcnt); end
    endtask

    task automatic test_single();
        r0a = 32'h3F800000; r0b = 32'h3F800000; r0v = 1'b1;
        #1;
        checks++; if ({r0r, r1r} !== 2'b10) begin failures++; $display("FAIL single_ready: got %b want 10", {r0r, r1r}); end
        step();
        r0v = 1'b0;
        #1;
        checks++; if ({busy, r0r, s0v} !== 3'b100) begin failures++; $display("FAIL single_exec: got busy,ready,valid=%b want 100", {busy, r0r, s0v}); end
        checks++; if (add_a !== 32'h3F800000 || add_b !== 32'h3F800000) begin failures++; $display("FAIL single_add_ops: got %h %h want 3f800000 3f800000", add_a, add_b); end
        step();
        checks++; if (s0v !== 1'b1 || s0res !== 32'h40000000) begin failures++; $display("FAIL single_rsp: got valid=%b result=%h want 1 40000000", s0v, s0res); end
        checks++; if (s1v !== 1'b0 || s1res !== 32'd0) begin failures++; $display("FAIL single_other_rsp: got valid=%b result=%h want 0 0", s1v, s1res); end
        s0r = 1'b1;
        step();
        s0r = 1'b0;
        #1;
        checks++; if (s0v !== 1'b0 || busy !== 1'b0 || s0res !== 32'd0) begin failures++; $display("FAIL single_done: got valid=%b busy=%b result=%h want 0 0 0", s0v, busy, s0res); end
        checks++; if (dcnt !== 16'd1) begin failures++; $display("FAIL single_done_count: got %0d want 1", dcnt); end
        checks++; if (add_a !== 32'h3F800000) begin failures++; $display("FAIL single_add_hold: got %h want 3f800000", add_a); end
    endtask

    task automatic test_contention();
        do_reset();
        r0a = 32'h3FC00000; r0b = 32'h40200000; r1a = 32'h40000000; r1b = 32'h40400000;
        r0v = 1'b1; r1v = 1'b1;
        #1;
        checks++; if ({r0r, r1r} !== 2'b10) begin failures++; $display("FAIL cont_first_grant: got %b want 10", {r0r, r1r}); end
        step();
        r0v = 1'b0;
        s1r = 1'b1;  // ignored: no response pending on channel 1
        #1;
        checks++; if (r1r !== 1'b0) begin failures++; $display("FAIL cont_ready_busy_exec: got %b want 0", r1r); end
        step();
        checks++; if (s0v !== 1'b1 || s0res !== 32'h40800000) begin failures++; $display("FAIL cont_rsp0: got valid=%b result=%h want 1 40800000", s0v, s0res); end
        checks++; if (r1r !== 1'b0 || s1v !== 1'b0) begin failures++; $display("FAIL cont_ready_busy_resp: got ready=%b rsp1_valid=%b want 0 0", r1r, s1v); end
        s1r = 1'b0;
        s0r = 1'b1;
        step();
        s0r = 1'b0;
        #1;
        checks++; if ({r0r, r1r} !== 2'b01) begin failures++; $display("FAIL cont_second_grant: got %b want 01", {r0r, r1r}); end
        step();
        r1v = 1'b0;
        step();
        checks++; if (s1v !== 1'b1 || s1res !== 32'h40A00000) begin failures++; $display("FAIL cont_rsp1: got valid=%b result=%h want 1 40a00000", s1v, s1res); end
        checks++; if (s0v !== 1'b0 || s0res !== 32'd0) begin failures++; $display("FAIL cont_rsp0_quiet: got valid=%b result=%h want 0 0", s0v, s0res); end
        s1r = 1'b1;
        step();
        s1r = 1'b0;
        #1;
        checks++; if (dcnt !== 16'd2) begin failures++; $display("FAIL cont_done_count: got %0d want 2", dcnt); end
    endtask

    task automatic test_round_robin();
        int got;
        logic [31:0] exp_res;
        do_reset();
        r0a = 32'h00000100; r0b = 32'h00000023; r1a = 32'h00000200; r1b = 32'h00000045;
        r0v = 1'b1; r1v = 1'b1; s0r = 1'b1; s1r = 1'b1;
        #1;
        for (int t = 0; t < 6; t++) begin
            got = -1;
            for (int c = 0; c < 20 && got < 0; c++) begin
                if (r0r && r1r) got = 2;
                else if (r0r) got = 0;
                else if (r1r) got = 1;
                else step();
            end
            checks++; if (got !== (t % 2)) begin failures++; $display("FAIL rr_grant_%0d: got %0d want %0d", t, got, t % 2); end
            got = -1;
            for (int c = 0; c < 20 && got < 0; c++) begin
                step();
                if (s0v) got = 0;
                else if (s1v) got = 1;
            end
            exp_res = (t % 2 == 0) ? 32'h00000123 : 32'h00000245;
            checks++; if (got !== (t % 2) || (s0res | s1res) !== exp_res) begin failures++; $display("FAIL rr_rsp_%0d: got channel %0d result %h want %0d %h", t, got, s0res | s1res, t % 2, exp_res); end
        end
        r0v = 1'b0; r1v = 1'b0;
        step();
        s0r = 1'b0; s1r = 1'b0;
        #1;
        checks++; if (dcnt !== 16'd6 || busy !== 1'b0) begin failures++; $display("FAIL rr_done_count: got %0d busy=%b want 6 0", dcnt, busy); end
    endtask

    task automatic test_backpressure();
        do_reset();
        r1a = 32'h40000000; r1b = 32'h40400000; r1v = 1'b1;
        #1;
        checks++; if (r1r !== 1'b1) begin failures++; $display("FAIL bp_accept: got %b want 1", r1r); end
        step();
        r1v = 1'b0;
        r0a = 32'h00000010; r0b = 32'h00000020; r0v = 1'b1;
        step();
        for (int c = 0; c < 10; c++) begin
            checks++; if (s1v !== 1'b1 || s1res !== 32'h40A00000 || r0r !== 1'b0) begin failures++; $display("FAIL bp_hold_%0d: got valid=%b result=%h req0_ready=%b want 1 40a00000 0", c, s1v, s1res, r0r); end
            step();
        end
        s1r = 1'b1;
        step();
        s1r = 1'b0;
        #1;
        checks++; if (s1v !== 1'b0 || dcnt !== 16'd1) begin failures++; $display("FAIL bp_complete: got valid=%b count=%0d want 0 1", s1v, dcnt); end
        checks++; if (r0r !== 1'b1) begin failures++; $display("FAIL bp_next_grant: got %b want 1", r0r); end
        step();
        r0v = 1'b0;
        step();
        s0r = 1'b1;
        step();
        s0r = 1'b0;
        #1;
        checks++; if (dcnt !== 16'd2) begin failures++; $display("FAIL bp_done_count: got %0d want 2", dcnt); end
    endtask

    task automatic test_settle4();
        r0a4 = 32'h00000011; r0b4 = 32'h00000022; r0v4 = 1'b1;
        #1;
        checks++; if (r0r4 !== 1'b1) begin failures++; $display("FAIL s4_accept: got %b want 1", r0r4); end
        step();
        r0v4 = 1'b0;
        r0a4 = 32'hDEADBEEF; r0b4 = 32'hCAFEF00D;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (s0v4 !== 1'b0 || add_a4 !== 32'h00000011 || add_b4 !== 32'h00000022) begin failures++; $display("FAIL s4_exec_%0d: got valid=%b ops=%h %h want 0 00000011 00000022", k, s0v4, add_a4, add_b4); end
            if (k < 3) step();
        end
        step();
        checks++; if (s0v4 !== 1'b1 || s0res4 !== 32'h00000033) begin failures++; $display("FAIL s4_rsp: got valid=%b result=%h want 1 00000033", s0v4, s0res4); end
        s0r4 = 1'b1;
        step();
        s0r4 = 1'b0;
        #1;
        checks++; if (dcnt4 !== 16'd1) begin failures++; $display("FAIL s4_done_count: got %0d want 1", dcnt4); end
    endtask

    task automatic test_async_reset();
        r0a = 32'h3F800000; r0b = 32'h3F800000; r0v = 1'b1;
        step();
        r0v = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || dcnt !== 16'd2) begin failures++; $display("FAIL ar_pre: got busy=%b count=%0d want 1 2", busy, dcnt); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, r0r, r1r, s0v, s1v} !== 5'b0 || {add_a, add_b} !== 64'd0 || dcnt !== 16'd0) begin failures++; $display("FAIL ar_immediate: got flags=%b ops=%h %h count=%0d want 0 0 0 0", {busy, r0r, r1r, s0v, s1v}, add_a, add_b, dcnt); end
        step();
        rst_n = 1'b1;
        s0r = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (s0v !== 1'b0 || s1v !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ar_no_rsp_%0d: got rsp=%b%b busy=%b want 00 0", c, s0v, s1v, busy); end
        end
        s0r = 1'b0;
        checks++; if (dcnt !== 16'd0) begin failures++; $display("FAIL ar_done_count: got %0d want 0", dcnt); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        do_reset();
        test_settle4();
        test_backpressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
